legv8_mc_control: RTL

// - Multi-cycle main control FSM for the LEGv8 datapath. It is the producer of the ALUOp code that the ALU control unit consumes.
// - Sequences FETCH/DECODE/EXEC/MEM/WB for LDUR, STUR, ADD, SUB, AND, ORR, CBZ and B.
// - Stalls on a memory ready handshake.
// - Emits per-cycle datapath enables, plus a one-cycle retire pulse and a one-cycle illegal-opcode pulse.

---
 rtl/legv8_ctrl_pkg.sv | 27 ++
 rtl/legv8_opc_class.sv | 22 ++
 rtl/legv8_mc_control.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control path.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB,
    ST_MEM_WR, ST_R_EXEC, ST_R_WB, ST_CBZ_EX, ST_B_EX, ST_HALT
  } state_t;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ8 = 8'b10110100;
  localparam logic [5:0]  OPC_B6   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/legv8_opc_class.sv
// Opcode classifier: maps IR[31:21] onto the instruction classes the FSM branches on.
module legv8_opc_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        is_ld,
  output logic        is_st,
  output logic        is_r,
  output logic        is_cbz,
  output logic        is_b,
  output logic        is_bad
);

  assign is_ld  = (opcode == OPC_LDUR);
  assign is_st  = (opcode == OPC_STUR);
  assign is_r   = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                  (opcode == OPC_AND) || (opcode == OPC_ORR);
  assign is_cbz = (opcode[10:3] == OPC_CBZ8);
  assign is_b   = (opcode[10:5] == OPC_B6);
  assign is_bad = ~(is_ld | is_st | is_r | is_cbz | is_b);

endmodule

// File: rtl/legv8_mc_control.sv
// Multi-cycle LEGv8 main control FSM: state register plus a combinational
// output decode, so an async reset clears every strobe without a clock edge.
module legv8_mc_control
  import legv8_ctrl_pkg::*;
#(
  parameter int OPC_W        = 11,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic             retire,
  output logic             illegal
);

  state_t state_q, state_d;
  logic   is_st_q;
  logic   c_ld, c_st, c_r, c_cbz, c_b, c_bad;

  // The zero flag gates the PC load in the datapath, not here.
  wire unused_zero = zero;

  legv8_opc_class u_cls (
    .opcode (opcode[10:0]),
    .is_ld  (c_ld),
    .is_st  (c_st),
    .is_r   (c_r),
    .is_cbz (c_cbz),
    .is_b   (c_b),
    .is_bad (c_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      is_st_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) is_st_q <= c_st;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMM2;
        Reg2Loc = c_st | c_cbz;
        illegal = c_bad;
        if (c_ld || c_st)  state_d = ST_MEM_ADDR;
        else if (c_r)      state_d = ST_R_EXEC;
        else if (c_cbz)    state_d = ST_CBZ_EX;
        else if (c_b)      state_d = ST_B_EX;
        else               state_d = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = is_st_q ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        retire   = mem_ready;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_RTYPE;
        state_d = ST_R_WB;
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_CBZ_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_PASSB;
        Reg2Loc     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_B_EX: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
